// File: rtl/tt_pi_loop_filter.sv
// ---------------------------------------------------------------------------
// tt_pi_loop_filter
//
// Proportional-integral loop filter for the clock-generator control loop.
// Bang-bang phase-detector pulses (up = early, down = late) are turned into
// a signed oscillator control word. The integrator saturates instead of
// wrapping, the output word is clamped and registered, and a window-based
// lock detector optionally halves both gains once the loop is quiet
// (gear shift). The full accumulator is reachable via a scan chain.
//
// Ports:
//   i_clk_gen   in   1      loop-filter clock (rising edge)
//   i_rst_n     in   1      asynchronous active-low reset
//   i_up        in   1      phase detector early pulse (error -1)
//   i_down      in   1      phase detector late pulse  (error +1)
//   i_kp        in   4      proportional gain, unsigned
//   i_ki        in   4      integral gain, unsigned
//   i_gear_en   in   1      halve gains while locked
//   i_clear     in   1      synchronous accumulator / lock clear
//   i_scan_en   in   1      scan-shift mode (highest synchronous priority)
//   i_scan_in   in   1      scan data into accumulator bit 0
//   o_ctrl      out  OUT_W  registered, saturated control word
//   o_locked    out  1      lock indicator
//   o_sat       out  1      integrator clamped on last update
//   o_scan_out  out  1      accumulator MSB
// ---------------------------------------------------------------------------
module tt_pi_loop_filter #(
    parameter int ACC_W     = 24,
    parameter int OUT_W     = 16,
    parameter int WIN_W     = 6,
    parameter int LOCK_THR  = 4,
    parameter int LOCK_WINS = 4
) (
    input  logic             i_clk_gen,
    input  logic             i_rst_n,
    input  logic             i_up,
    input  logic             i_down,
    input  logic [3:0]       i_kp,
    input  logic [3:0]       i_ki,
    input  logic             i_gear_en,
    input  logic             i_clear,
    input  logic             i_scan_en,
    input  logic             i_scan_in,
    output logic [OUT_W-1:0] o_ctrl,
    output logic             o_locked,
    output logic             o_sat,
    output logic             o_scan_out
);

    // Output clamp limits expressed in the ACC_W+1 working width.
    localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((1 <<< (OUT_W-1)) - 1);
    localparam logic signed [ACC_W:0] OUT_MIN = (ACC_W+1)'(-(1 <<< (OUT_W-1)));
    localparam logic [WIN_W+1:0]      THR     = (WIN_W+2)'(LOCK_THR);
    localparam logic [3:0]            LW      = 4'(LOCK_WINS);

    logic [ACC_W-1:0]        acc;
    logic [WIN_W-1:0]        win_cnt;
    logic signed [WIN_W:0]   net;
    logic [3:0]              good_cnt;

    // Error decode: both or neither pulse means no error.
    logic err_pos, err_neg;
    assign err_pos = i_down & ~i_up;
    assign err_neg = i_up & ~i_down;

    // Gear shift halves (floor) both gains once locked.
    logic       gear_on;
    logic [3:0] kp_eff, ki_eff;
    assign gear_on = i_gear_en & o_locked;
    assign kp_eff  = gear_on ? {1'b0, i_kp[3:1]} : i_kp;
    assign ki_eff  = gear_on ? {1'b0, i_ki[3:1]} : i_ki;

    logic signed [ACC_W:0]   kp_term, ki_term, acc_ext, p_base, p_sum, i_sum;
    logic                    i_ovf;
    logic [ACC_W-1:0]        acc_upd;
    logic [OUT_W-1:0]        ctrl_next;

    assign acc_ext = $signed({acc[ACC_W-1], acc});

    always_comb begin
        kp_term = '0;
        ki_term = '0;
        if (err_pos) begin
            kp_term = $signed({{(ACC_W-3){1'b0}}, kp_eff});
            ki_term = $signed({{(ACC_W-3){1'b0}}, ki_eff});
        end else if (err_neg) begin
            kp_term = -$signed({{(ACC_W-3){1'b0}}, kp_eff});
            ki_term = -$signed({{(ACC_W-3){1'b0}}, ki_eff});
        end
    end

    // Integrator: one extra bit of headroom; the top two bits disagreeing
    // means the ACC_W-bit result would have wrapped, so clamp instead.
    assign i_sum = acc_ext + ki_term;
    assign i_ovf = i_sum[ACC_W] ^ i_sum[ACC_W-1];

    always_comb begin
        acc_upd = i_sum[ACC_W-1:0];
        if (i_ovf) begin
            acc_upd = i_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                   : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    // Proportional output uses the pre-update accumulator; a clear zeroes
    // the integral contribution but keeps the proportional kick.
    assign p_base = i_clear ? '0 : acc_ext;
    assign p_sum  = p_base + kp_term;

    always_comb begin
        ctrl_next = p_sum[OUT_W-1:0];
        if (p_sum > OUT_MAX) begin
            ctrl_next = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (p_sum < OUT_MIN) begin
            ctrl_next = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end

    // Lock detector. The net sum of a full window can reach +/-2^WIN_W,
    // which needs one more bit than the stored register, so the window-end
    // test is done at WIN_W+2 bits.
    logic signed [WIN_W+1:0] err_ext, net_tot;
    logic [WIN_W+1:0]        net_abs;
    logic                    win_wrap, quiet;
    logic [3:0]              good_next;
    logic signed [WIN_W:0]   net_next;

    assign err_ext  = err_pos ? (WIN_W+2)'(1) : (err_neg ? '1 : '0);
    assign net_tot  = $signed({net[WIN_W], net}) + err_ext;
    assign net_abs  = net_tot[WIN_W+1] ? $unsigned(-net_tot) : $unsigned(net_tot);
    assign quiet    = (net_abs <= THR);
    assign win_wrap = &win_cnt;

    always_comb begin
        good_next = good_cnt;
        net_next  = net_tot[WIN_W:0];
        if (win_wrap) begin
            net_next = '0;
            if (!quiet) begin
                good_next = '0;
            end else if (good_cnt != LW) begin
                good_next = good_cnt + 4'd1;
            end
        end
    end

    always_ff @(posedge i_clk_gen or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc      <= '0;
            o_ctrl   <= '0;
            o_sat    <= 1'b0;
            o_locked <= 1'b0;
            win_cnt  <= '0;
            net      <= '0;
            good_cnt <= '0;
        end else if (i_scan_en) begin
            // Scan freezes everything except the accumulator shift.
            acc <= {acc[ACC_W-2:0], i_scan_in};
        end else if (i_clear) begin
            acc      <= '0;
            o_ctrl   <= ctrl_next;
            o_sat    <= 1'b0;
            o_locked <= 1'b0;
            win_cnt  <= '0;
            net      <= '0;
            good_cnt <= '0;
        end else begin
            acc      <= acc_upd;
            o_ctrl   <= ctrl_next;
            o_sat    <= i_ovf;
            win_cnt  <= win_cnt + 1'b1;
            net      <= net_next;
            good_cnt <= good_next;
            o_locked <= (good_next == LW);
        end
    end

    assign o_scan_out = acc[ACC_W-1];

endmodule

// File: tb/tb_tt_pi_loop_filter.sv
// ---------------------------------------------------------------------------
// tb_tt_pi_loop_filter
//
// Directed bench for tt_pi_loop_filter with default parameters
// (ACC_W=24, OUT_W=16, WIN_W=6, LOCK_THR=4, LOCK_WINS=4). Inputs change
// 1 time unit after a rising edge; outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_tt_pi_loop_filter;

    logic        i_clk_gen;
    logic        i_rst_n;
    logic        i_up;
    logic        i_down;
    logic [3:0]  i_kp;
    logic [3:0]  i_ki;
    logic        i_gear_en;
    logic        i_clear;
    logic        i_scan_en;
    logic        i_scan_in;
    logic [15:0] o_ctrl;
    logic        o_locked;
    logic        o_sat;
    logic        o_scan_out;

    int checks = 0;
    int errors = 0;

    tt_pi_loop_filter dut (
        .i_clk_gen (i_clk_gen),
        .i_rst_n   (i_rst_n),
        .i_up      (i_up),
        .i_down    (i_down),
        .i_kp      (i_kp),
        .i_ki      (i_ki),
        .i_gear_en (i_gear_en),
        .i_clear   (i_clear),
        .i_scan_en (i_scan_en),
        .i_scan_in (i_scan_in),
        .o_ctrl    (o_ctrl),
        .o_locked  (o_locked),
        .o_sat     (o_sat),
        .o_scan_out(o_scan_out)
    );

    // Clock: period 10, rising edges at 5, 15, 25, ...
    initial i_clk_gen = 1'b0;
    always #5 i_clk_gen = ~i_clk_gen;

    task automatic step();
        @(posedge i_clk_gen);
        #1;
    endtask

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_up = 0; i_down = 0; i_clear = 0; i_scan_en = 0; i_scan_in = 0;
        i_rst_n = 0;
        step();
        i_rst_n = 1;
    endtask

    // Shift a 24-bit value in MSB first; scan mode is left enabled.
    task automatic scan_load(input logic [23:0] v);
        i_scan_en = 1;
        for (int i = 23; i >= 0; i--) begin
            i_scan_in = v[i];
            step();
        end
        i_scan_in = 0;
    endtask

    logic [23:0] pat;

    initial begin
        i_rst_n = 1; i_up = 0; i_down = 0; i_kp = 0; i_ki = 0;
        i_gear_en = 0; i_clear = 0; i_scan_en = 0; i_scan_in = 0;
        #2;
        do_reset();

        // Reset state
        check("rst_ctrl", $signed(o_ctrl), 0);
        check("rst_locked", o_locked, 0);
        check("rst_sat", o_sat, 0);
        check("rst_scan_out", o_scan_out, 0);

        // Ramp: acc 0,4,8,12 ; ctrl 7,11,15,19
        i_kp = 7; i_ki = 4; i_down = 1;
        step(); check("ramp1", $signed(o_ctrl), 7);
        step(); check("ramp2", $signed(o_ctrl), 11);
        step(); check("ramp3", $signed(o_ctrl), 15);
        step(); check("ramp4", $signed(o_ctrl), 19);
        check("ramp_sat", o_sat, 0);

        // Integrator saturation from 0x7FFFFE
        i_down = 0;
        scan_load(24'h7FFFFE);
        check("scan_hold_ctrl", $signed(o_ctrl), 19);
        i_scan_en = 0;
        i_down = 1;
        step(); check("isat1_ctrl", $signed(o_ctrl), 32767);
        check("isat1_sat", o_sat, 1);
        step(); check("isat2_ctrl", $signed(o_ctrl), 32767);
        check("isat2_sat", o_sat, 1);
        i_down = 0;
        step(); check("isat3_ctrl", $signed(o_ctrl), 32767);
        check("isat3_sat", o_sat, 0);

        // Negative output clamp from acc = -40000
        scan_load(24'hFF63C0);
        check("scan_hold_ctrl2", $signed(o_ctrl), 32767);
        i_scan_en = 0;
        i_up = 1; i_kp = 15; i_ki = 4;
        step(); check("nclamp1", $signed(o_ctrl), -32768);
        check("nclamp1_sat", o_sat, 0);
        step(); check("nclamp2", $signed(o_ctrl), -32768);
        i_up = 0;

        // Scan round trip
        pat = 24'hA5C3F0;
        scan_load(pat);
        check("rt_bit23", o_scan_out, pat[23]);
        for (int i = 22; i >= 0; i--) begin
            step();
            check("rt_bit", o_scan_out, pat[i]);
        end
        step();
        check("rt_ctrl_hold", $signed(o_ctrl), -32768);
        check("rt_locked_hold", o_locked, 0);

        // acc = 1000, then clear and async reset
        scan_load(24'd1000);
        i_scan_en = 0;
        i_kp = 7; i_ki = 4; i_down = 1;
        step(); check("a1000_1", $signed(o_ctrl), 1007);
        step(); check("a1000_2", $signed(o_ctrl), 1011);
        i_clear = 1;
        step(); check("clr_ctrl", $signed(o_ctrl), 7);
        check("clr_locked", o_locked, 0);
        check("clr_sat", o_sat, 0);
        i_clear = 0;
        step(); check("postclr1", $signed(o_ctrl), 7);
        step(); check("postclr2", $signed(o_ctrl), 11);
        #2;
        i_rst_n = 0;
        #1;
        check("arst_ctrl", $signed(o_ctrl), 0);
        check("arst_locked", o_locked, 0);
        check("arst_sat", o_sat, 0);
        check("arst_scan_out", o_scan_out, 0);
        step();
        i_rst_n = 1;
        i_down = 0;

        // Lock and gear shift: alternate down/up, edge k odd -> down
        i_kp = 8; i_ki = 6; i_gear_en = 1;
        for (int k = 1; k <= 256; k++) begin
            i_down = (k % 2 == 1);
            i_up   = (k % 2 == 0);
            step();
            if (k == 1)   check("lk_ctrl_k1", $signed(o_ctrl), 8);
            if (k == 2)   check("lk_ctrl_k2", $signed(o_ctrl), -2);
            if (k == 255) check("lk_unlocked_255", o_locked, 0);
            if (k == 256) begin
                check("lk_locked_256", o_locked, 1);
                check("lk_ctrl_256", $signed(o_ctrl), -2);
            end
        end
        i_down = 1; i_up = 0;
        step(); check("gear_ctrl_257", $signed(o_ctrl), 4);
        i_down = 0; i_up = 1;
        step(); check("gear_ctrl_258", $signed(o_ctrl), -1);
        i_down = 1; i_up = 0;
        step(); check("gear_ctrl_259", $signed(o_ctrl), 4);
        // Edges 260..320: window ends at 320 with net 62 -> unlock
        for (int k = 260; k <= 320; k++) begin
            step();
            if (k == 319) check("lk_still_319", o_locked, 1);
            if (k == 320) check("lk_drop_320", o_locked, 0);
        end
        step(); check("ungear_ctrl_321", $signed(o_ctrl), 194);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
